// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared FSM encoding, width limits and counter sizing for the bit-serial adder
package serial_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int WIDTH_MIN = 1;
    localparam int WIDTH_MAX = 32;

    function automatic int cnt_w(input int w);
        return (w < 2) ? 1 : $clog2(w + 1);
    endfunction

endpackage

// File: rtl/serial_adder_fa.sv
// fa: one-bit full adder, the single arithmetic cell of the serial adder
module fa (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// serial_adder: LSB-first bit-serial WIDTH-bit adder using one fa cell and a carry flop
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = cnt_w(WIDTH);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] s_sr_q, s_sr_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             c_q, c_d;
    logic             cout_q, cout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             fa_sum, fa_cout;
    logic             last;
    logic [WIDTH-1:0] s_next;

    fa u_fa (
        .a    (a_sr_q[0]),
        .b    (b_sr_q[0]),
        .cin  (c_q),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    // next-state: load on accepted start, shift one bit pair per RUN cycle, publish result on the last bit
    always_comb begin
        state_d = state_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        s_sr_d  = s_sr_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        c_d     = c_q;
        cout_d  = cout_q;
        s_next  = (s_sr_q >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));
        last    = (cnt_q == CW'(WIDTH - 1));
        if (state_q == ST_IDLE) begin
            if (start) begin
                state_d = ST_RUN;
                a_sr_d  = a;
                b_sr_d  = b;
                c_d     = cin;
                cnt_d   = '0;
            end
        end else if (state_q == ST_RUN) begin
            a_sr_d = a_sr_q >> 1;
            b_sr_d = b_sr_q >> 1;
            s_sr_d = s_next;
            c_d    = fa_cout;
            cnt_d  = cnt_q + 1'b1;
            if (last) begin
                state_d = ST_DONE;
                sum_d   = s_next;
                cout_d  = fa_cout;
            end
        end else begin
            state_d = ST_IDLE;
        end
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    // state and datapath registers; reset aborts any operation and clears the result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            s_sr_q  <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            c_q     <= 1'b0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            s_sr_q  <= s_sr_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule
